// File: rtl/fpga_template_pkg.sv
// Shared types and defaults for the debug byte path (debug TX FIFO and its register-bank view).
package fpga_template_pkg;

    localparam int DBG_FIFO_DEPTH   = 16;
    localparam int DBG_GAP_CYCLES   = 0;
    localparam int DBG_BUSY_TIMEOUT = 64;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } dbg_tx_state_t;

    typedef struct packed {
        logic [7:0]                        ovf_cnt;
        logic [$clog2(DBG_FIFO_DEPTH):0]   level;
        logic                              timeout_flag;
    } rb_dbg_tx_status_t;

endpackage

// File: rtl/sync_fifo_8b.sv
// DEPTH x 8 register-array FIFO; occupancy is tracked by a level counter so full/empty never
// depend on pointer equality.
module sync_fifo_8b #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          resetb,
    input  logic          push,
    input  logic [7:0]    wr_data,
    input  logic          pop,
    output logic [7:0]    rd_data,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          do_push, do_pop;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem_q[rd_ptr_q];
    assign level   = level_q;

    // Pointers are exactly AW bits wide, so wrap from DEPTH-1 to 0 is the natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      level_d = level_q + 1'b1;
        else if (!do_push && do_pop) level_d = level_q - 1'b1;
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/debug_tx_fifo.sv
// Buffers debug bytes and paces them into the UART debug-send port with a send/busy handshake,
// counting writes dropped on overflow.
module debug_tx_fifo
    import fpga_template_pkg::*;
#(
    parameter  int DEPTH        = DBG_FIFO_DEPTH,
    parameter  int GAP_CYCLES   = DBG_GAP_CYCLES,
    parameter  int BUSY_TIMEOUT = DBG_BUSY_TIMEOUT,
    localparam int AW           = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          resetb,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          tx_send,
    output logic [7:0]    tx_data,
    input  logic          tx_busy,
    output logic [7:0]    ovf_cnt,
    input  logic          ovf_clr,
    output logic          timeout_flag
);

    localparam int TMAX = (BUSY_TIMEOUT > GAP_CYCLES) ? BUSY_TIMEOUT : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    dbg_tx_state_t state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic [7:0]    ovf_cnt_q, ovf_cnt_d;
    logic          tflag_q, tflag_d;
    logic          pop, tout_set;
    logic [7:0]    head;

    sync_fifo_8b #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .resetb  (resetb),
        .push    (wr_en),
        .wr_data (wr_data),
        .pop     (pop),
        .rd_data (head),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        tx_data_d = tx_data_q;
        pop       = 1'b0;
        tx_send   = 1'b0;
        tout_set  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && !tx_busy) begin
                    pop       = 1'b1;
                    tx_data_d = head;
                    state_d   = SEND;
                end
            end
            SEND: begin
                tx_send = 1'b1;
                timer_d = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (timer_q == TW'(BUSY_TIMEOUT - 1)) begin
                    // Transmitter never acknowledged; treat the byte as sent and flag it.
                    tout_set = 1'b1;
                    timer_d  = '0;
                    state_d  = GAP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    timer_d = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (GAP_CYCLES <= 1 || timer_q == TW'(GAP_CYCLES - 1)) state_d = IDLE;
                else timer_d = timer_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Overflow is judged on full before any same-cycle pop; clear wins over increment and set.
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        tflag_d   = tflag_q;
        if (ovf_clr) begin
            ovf_cnt_d = '0;
            tflag_d   = 1'b0;
        end else begin
            if (wr_en && full && ovf_cnt_q != 8'hFF) ovf_cnt_d = ovf_cnt_q + 1'b1;
            if (tout_set) tflag_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            tx_data_q <= '0;
            ovf_cnt_q <= '0;
            tflag_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            tx_data_q <= tx_data_d;
            ovf_cnt_q <= ovf_cnt_d;
            tflag_q   <= tflag_d;
        end
    end

    assign tx_data      = tx_data_q;
    assign ovf_cnt      = ovf_cnt_q;
    assign timeout_flag = tflag_q;

endmodule

// File: tb/tb_debug_tx_fifo.sv
// Scoreboard bench: stimulus queues expected bytes, a negedge monitor checks every tx_send.
module tb_debug_tx_fifo;

    logic       clk = 1'b0;
    logic       resetb, wr_en0, wr_en1, ovf_clr;
    logic [7:0] wr_data;
    logic       tx_busy = 1'b0;

    logic       full0, empty0, tx_send0, tflag0;
    logic [4:0] level0;
    logic [7:0] tx_data0, ovf0;
    logic       full1, empty1, tx_send1, tflag1;
    logic [4:0] level1;
    logic [7:0] tx_data1, ovf1;

    int         checks = 0, passes = 0, sends0 = 0, cyc = 0;
    logic [7:0] exp_q [$];
    int         busy_len = 10, rem = 0;
    logic       force_busy = 1'b0, send_seen;

    always #5 clk = ~clk;

    debug_tx_fifo dut0 (
        .clk(clk), .resetb(resetb), .wr_en(wr_en0), .wr_data(wr_data),
        .full(full0), .empty(empty0), .level(level0), .tx_send(tx_send0),
        .tx_data(tx_data0), .tx_busy(tx_busy), .ovf_cnt(ovf0), .ovf_clr(ovf_clr),
        .timeout_flag(tflag0)
    );

    debug_tx_fifo #(.GAP_CYCLES(8)) dut1 (
        .clk(clk), .resetb(resetb), .wr_en(wr_en1), .wr_data(wr_data),
        .full(full1), .empty(empty1), .level(level1), .tx_send(tx_send1),
        .tx_data(tx_data1), .tx_busy(tx_busy), .ovf_cnt(ovf1), .ovf_clr(ovf_clr),
        .timeout_flag(tflag1)
    );

    // Transmitter model: busy rises the cycle after tx_send and stays up busy_len cycles.
    always @(posedge clk) begin
        cyc++;
        send_seen = tx_send0 | tx_send1;
        #1;
        if (send_seen) rem = busy_len;
        else if (rem > 0) rem--;
        tx_busy = force_busy || (rem > 0);
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic mon_send(input string nm, input logic [7:0] d);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL %s unexpected send: got 0x%0h expected none", nm, d);
        end else begin
            e = exp_q.pop_front();
            chk({nm, " data"}, d, e);
            chk({nm, " busy low at send"}, tx_busy, 0);
        end
    endtask

    always @(negedge clk) begin
        if (tx_send0) begin
            sends0++;
            mon_send("send0", tx_data0);
        end
        if (tx_send1) mon_send("send1", tx_data1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr0(input logic [7:0] d, input bit expect_send);
        wr_en0  = 1'b1;
        wr_data = d;
        if (expect_send) exp_q.push_back(d);
        tick();
        wr_en0 = 1'b0;
    endtask

    task automatic wr1(input logic [7:0] d);
        wr_en1  = 1'b1;
        wr_data = d;
        exp_q.push_back(d);
        tick();
        wr_en1 = 1'b0;
    endtask

    task automatic wait_drain(input string nm, input int max);
        for (int k = 0; k < max && exp_q.size() != 0; k++) tick();
        chk(nm, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int c0, c1, s;
        resetb = 1'b0; wr_en0 = 1'b0; wr_en1 = 1'b0; wr_data = '0; ovf_clr = 1'b0;
        #12;
        chk("rst level", level0, 0);
        chk("rst empty", empty0, 1);
        chk("rst full", full0, 0);
        chk("rst tx_send", tx_send0, 0);
        chk("rst tx_data", tx_data0, 0);
        chk("rst ovf", ovf0, 0);
        chk("rst tflag", tflag0, 0);
        tick();
        resetb = 1'b1;
        tick();

        // Three back-to-back bytes through a 10-cycle-busy transmitter
        wr0(8'h44, 1); wr0(8'h42, 1); wr0(8'h47, 1);
        wait_drain("t1 drain", 200);
        repeat (20) tick();
        chk("t1 level", level0, 0);
        chk("t1 empty", empty0, 1);

        // Fill past full while transmitter is held busy
        force_busy = 1'b1;
        tick(); tick();
        for (int i = 0; i < 20; i++) begin
            wr_en0  = 1'b1;
            wr_data = 8'(i);
            if (i < 16) exp_q.push_back(8'(i));
            tick();
            if (i == 14) chk("t2 not full at 15", full0, 0);
            if (i == 15) chk("t2 full at 16", full0, 1);
        end
        wr_en0 = 1'b0;
        chk("t2 ovf", ovf0, 4);
        chk("t2 level", level0, 16);
        force_busy = 1'b0;
        wait_drain("t2 drain", 600);
        repeat (20) tick();
        chk("t2 empty", empty0, 1);

        // Saturation, then clear colliding with an overflowing write
        force_busy = 1'b1;
        tick(); tick();
        for (int i = 0; i < 16; i++) wr0(8'h80 + 8'(i), 1);
        for (int i = 0; i < 260; i++) wr0(8'hEE, 0);
        chk("t3 ovf saturate", ovf0, 255);
        wr_en0 = 1'b1; wr_data = 8'hEE; ovf_clr = 1'b1;
        tick();
        wr_en0 = 1'b0; ovf_clr = 1'b0;
        chk("t3 clr beats ovf", ovf0, 0);
        wr0(8'hEE, 0);
        chk("t3 ovf after clr", ovf0, 1);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        chk("t3 clr alone", ovf0, 0);
        chk("t3 level", level0, 16);
        force_busy = 1'b0;
        wait_drain("t3 drain", 600);
        repeat (20) tick();

        // Busy timeout: transmitter never acknowledges
        busy_len = 0;
        wr0(8'hA5, 1);
        repeat (65) tick();
        chk("t4 tflag before timeout", tflag0, 0);
        tick();
        chk("t4 tflag at timeout", tflag0, 1);
        chk("t4 A5 sent", exp_q.size(), 0);
        wr0(8'h5A, 1);
        wait_drain("t4 next byte", 100);
        repeat (80) tick();
        chk("t4 tflag sticky", tflag0, 1);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        chk("t4 tflag cleared", tflag0, 0);

        // Inter-byte gap of 8 cycles on the second instance
        busy_len = 3;
        wr1(8'h11); wr1(8'h22);
        for (int k = 0; k < 100 && !tx_busy; k++) tick();
        for (int k = 0; k < 100 && tx_busy; k++) tick();
        c0 = cyc;
        for (int k = 0; k < 100 && !tx_send1; k++) tick();
        c1 = cyc;
        chk("t5 gap >= 9 cycles", int'((c1 - c0) >= 9), 1);
        wait_drain("t5 drain", 100);
        repeat (20) tick();
        chk("t5 level1", level1, 0);

        // Reset during WAIT_DONE with 5 bytes still queued
        busy_len = 10;
        wr0(8'h60, 1);
        for (int i = 1; i < 6; i++) wr0(8'h60 + 8'(i), 0);
        wait_drain("t6 first send", 50);
        repeat (3) tick();
        chk("t6 queued", level0, 5);
        resetb = 1'b0;
        #1;
        chk("t6 rst level", level0, 0);
        chk("t6 rst tx_send", tx_send0, 0);
        chk("t6 rst empty", empty0, 1);
        chk("t6 rst tx_data", tx_data0, 0);
        tick();
        resetb = 1'b1;
        s = sends0;
        repeat (40) tick();
        chk("t6 no sends after rst", sends0, s);
        wr0(8'h77, 1);
        wait_drain("t6 new write sent", 100);
        repeat (20) tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
